// File: rtl/itch_rx_frame_sequencer.sv
// Frame sequencer for 802.1Q/IPv4/UDP/MoldUDP64 receive frames.
// Counts beats, checks headers, raises layer strobes and gates ITCH payload.
module itch_rx_frame_sequencer #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WORD = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      rx_data_net,
    input  logic             rx_sof_net,
    input  logic             rx_eof_net,
    input  logic [2:0]       rx_len_net,
    input  logic             rx_vld_net,
    input  logic [15:0]      cfg_udp_port,
    input  logic             cfg_port_chk_en,
    output logic [6:0]       word_cnt,
    output logic [63:0]      data_out,
    output logic             eth_en,
    output logic             ip_en,
    output logic             udp_en,
    output logic             mold_en,
    output logic             payload_vld,
    output logic             payload_sof,
    output logic             payload_eof,
    output logic [2:0]       payload_len,
    output logic [15:0]      msg_count,
    output logic             frame_ok,
    output logic             frame_drop,
    output logic [2:0]       drop_cause,
    output logic             end_of_session,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

    state_t     state_q;
    logic [6:0] word_cnt_q;
    logic [6:0] beat_idx_d;
    logic [2:0] hdr_cause_d;
    logic [3:0] strobe_d;
    logic [15:0] mc_d;

    assign word_cnt = word_cnt_q;

    always_comb begin
        beat_idx_d = '0;
        if (!rx_sof_net) begin
            beat_idx_d = (word_cnt_q == 7'(MAX_WORD)) ? word_cnt_q : word_cnt_q + 7'd1;
        end
        hdr_cause_d = '0;
        case (beat_idx_d)
            7'd1: if (rx_data_net[31:16] != 16'h8100) hdr_cause_d = 3'd1;
            7'd2: begin
                if (rx_data_net[63:48] != 16'h0800)     hdr_cause_d = 3'd2;
                else if (rx_data_net[47:40] != 8'h45)   hdr_cause_d = 3'd3;
            end
            7'd3: if (rx_data_net[39:32] != 8'h11) hdr_cause_d = 3'd4;
            7'd5: if (cfg_port_chk_en && rx_data_net[63:48] != cfg_udp_port) hdr_cause_d = 3'd5;
            default: hdr_cause_d = '0;
        endcase
        strobe_d[3] = (beat_idx_d <= 7'd2);
        strobe_d[2] = (beat_idx_d >= 7'd2) && (beat_idx_d <= 7'd4);
        strobe_d[1] = (beat_idx_d >= 7'd4) && (beat_idx_d <= 7'd5);
        strobe_d[0] = (beat_idx_d >= 7'd5) && (beat_idx_d <= 7'd8);
        // Word 8 carries the message count itself, so use it directly on that beat.
        mc_d = (beat_idx_d == 7'd8) ? rx_data_net[63:48] : msg_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            word_cnt_q     <= '0;
            data_out       <= '0;
            eth_en         <= 1'b0;
            ip_en          <= 1'b0;
            udp_en         <= 1'b0;
            mold_en        <= 1'b0;
            payload_vld    <= 1'b0;
            payload_sof    <= 1'b0;
            payload_eof    <= 1'b0;
            payload_len    <= '0;
            msg_count      <= '0;
            frame_ok       <= 1'b0;
            frame_drop     <= 1'b0;
            drop_cause     <= '0;
            end_of_session <= 1'b0;
            ok_cnt         <= '0;
            drop_cnt       <= '0;
        end else begin
            eth_en         <= 1'b0;
            ip_en          <= 1'b0;
            udp_en         <= 1'b0;
            mold_en        <= 1'b0;
            payload_vld    <= 1'b0;
            payload_sof    <= 1'b0;
            payload_eof    <= 1'b0;
            payload_len    <= '0;
            frame_ok       <= 1'b0;
            frame_drop     <= 1'b0;
            drop_cause     <= '0;
            end_of_session <= 1'b0;
            if (rx_vld_net) begin
                data_out <= rx_data_net;
                if (rx_sof_net) begin
                    word_cnt_q <= '0;
                    eth_en     <= 1'b1;
                    state_q    <= rx_eof_net ? S_IDLE : S_HDR;
                    if (state_q == S_HDR || state_q == S_PAYLOAD) begin
                        frame_drop <= 1'b1;
                        drop_cause <= 3'd7;
                        drop_cnt   <= drop_cnt + 1'b1;
                    end else if (rx_eof_net) begin
                        frame_drop <= 1'b1;
                        drop_cause <= 3'd6;
                        drop_cnt   <= drop_cnt + 1'b1;
                    end
                end else begin
                    case (state_q)
                        S_HDR: begin
                            word_cnt_q <= beat_idx_d;
                            {eth_en, ip_en, udp_en, mold_en} <= strobe_d;
                            if (hdr_cause_d != 3'd0) begin
                                frame_drop <= 1'b1;
                                drop_cause <= hdr_cause_d;
                                drop_cnt   <= drop_cnt + 1'b1;
                                state_q    <= rx_eof_net ? S_IDLE : S_DROP;
                            end else if (beat_idx_d == 7'd8) begin
                                msg_count   <= mc_d;
                                payload_vld <= (mc_d != 16'h0000);
                                payload_sof <= (mc_d != 16'h0000);
                                state_q     <= rx_eof_net ? S_IDLE : S_PAYLOAD;
                                if (rx_eof_net) begin
                                    payload_eof    <= (mc_d != 16'h0000);
                                    payload_len    <= (mc_d != 16'h0000) ? rx_len_net : 3'd0;
                                    frame_ok       <= 1'b1;
                                    ok_cnt         <= ok_cnt + 1'b1;
                                    end_of_session <= (mc_d == 16'hFFFF);
                                end
                            end else if (rx_eof_net) begin
                                frame_drop <= 1'b1;
                                drop_cause <= 3'd6;
                                drop_cnt   <= drop_cnt + 1'b1;
                                state_q    <= S_IDLE;
                            end
                        end
                        S_PAYLOAD: begin
                            word_cnt_q  <= beat_idx_d;
                            payload_vld <= (msg_count != 16'h0000);
                            if (rx_eof_net) begin
                                payload_eof    <= (msg_count != 16'h0000);
                                payload_len    <= (msg_count != 16'h0000) ? rx_len_net : 3'd0;
                                frame_ok       <= 1'b1;
                                ok_cnt         <= ok_cnt + 1'b1;
                                end_of_session <= (msg_count == 16'hFFFF);
                                state_q        <= S_IDLE;
                            end
                        end
                        S_DROP: begin
                            word_cnt_q <= beat_idx_d;
                            if (rx_eof_net) state_q <= S_IDLE;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_itch_rx_frame_sequencer.sv
// Directed bench for itch_rx_frame_sequencer: per-scenario tasks with inline checks.
module tb_itch_rx_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] rx_data_net = '0;
    logic        rx_sof_net = 1'b0;
    logic        rx_eof_net = 1'b0;
    logic [2:0]  rx_len_net = '0;
    logic        rx_vld_net = 1'b0;
    logic [15:0] cfg_udp_port = 16'h1234;
    logic        cfg_port_chk_en = 1'b1;
    logic [6:0]  word_cnt;
    logic [63:0] data_out;
    logic        eth_en, ip_en, udp_en, mold_en;
    logic        payload_vld, payload_sof, payload_eof;
    logic [2:0]  payload_len;
    logic [15:0] msg_count;
    logic        frame_ok, frame_drop;
    logic [2:0]  drop_cause;
    logic        end_of_session;
    logic [15:0] ok_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    logic [63:0] frm [0:9];

    itch_rx_frame_sequencer #(.CNT_W(16), .MAX_WORD(127)) dut (
        .clk(clk), .rst(rst_n),
        .rx_data_net(rx_data_net), .rx_sof_net(rx_sof_net), .rx_eof_net(rx_eof_net),
        .rx_len_net(rx_len_net), .rx_vld_net(rx_vld_net),
        .cfg_udp_port(cfg_udp_port), .cfg_port_chk_en(cfg_port_chk_en),
        .word_cnt(word_cnt), .data_out(data_out),
        .eth_en(eth_en), .ip_en(ip_en), .udp_en(udp_en), .mold_en(mold_en),
        .payload_vld(payload_vld), .payload_sof(payload_sof), .payload_eof(payload_eof),
        .payload_len(payload_len), .msg_count(msg_count),
        .frame_ok(frame_ok), .frame_drop(frame_drop), .drop_cause(drop_cause),
        .end_of_session(end_of_session), .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic build_frame(input logic [15:0] port, input logic [15:0] mc);
        for (int i = 0; i < 10; i++) frm[i] = {32'hA5A5_0000, 32'(i)};
        frm[1] = {32'h0011_2233, 16'h8100, 16'h0064};
        frm[2] = {16'h0800, 8'h45, 40'h00_0000_1111};
        frm[3] = {24'h40_0000, 8'h11, 32'hC0A8_0001};
        frm[5] = {port, 48'h0000_4D4F_4C44};
        frm[8] = {mc, 48'h0000_4142_4344};
        frm[9] = 64'h4142_4344_4546_4748;
    endtask

    task automatic send(input logic [63:0] d, input logic sof, input logic eof, input logic [2:0] len);
        @(negedge clk);
        rx_data_net = d; rx_sof_net = sof; rx_eof_net = eof; rx_len_net = len; rx_vld_net = 1'b1;
        @(posedge clk); #1;
        rx_vld_net = 1'b0; rx_sof_net = 1'b0; rx_eof_net = 1'b0;
    endtask

    task automatic stall();
        @(negedge clk);
        rx_vld_net = 1'b0; rx_data_net = 64'hDEAD_BEEF_DEAD_BEEF; rx_sof_net = 1'b1; rx_eof_net = 1'b1;
        @(posedge clk); #1;
        rx_sof_net = 1'b0; rx_eof_net = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (word_cnt !== 7'd0) begin errors++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if ({frame_ok, frame_drop, payload_vld, eth_en} !== 4'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {frame_ok, frame_drop, payload_vld, eth_en}); end
        checks++; if ({ok_cnt, drop_cnt} !== 32'd0) begin errors++; $display("FAIL reset_counters got=%h exp=0", {ok_cnt, drop_cnt}); end
    endtask

    task automatic test_valid_frame();
        build_frame(16'h1234, 16'd3);
        cfg_udp_port = 16'h1234; cfg_port_chk_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(frm[i], i == 0, i == 9, 3'd5);
            checks++; if (word_cnt !== 7'(i)) begin errors++; $display("FAIL valid_word_cnt beat=%0d got=%0d exp=%0d", i, word_cnt, i); end
            checks++; if (data_out !== frm[i]) begin errors++; $display("FAIL valid_data_out beat=%0d got=%h exp=%h", i, data_out, frm[i]); end
            checks++; if ({eth_en, ip_en, udp_en, mold_en} !== {i <= 2, i >= 2 && i <= 4, i >= 4 && i <= 5, i >= 5 && i <= 8})
                begin errors++; $display("FAIL valid_strobes beat=%0d got=%b", i, {eth_en, ip_en, udp_en, mold_en}); end
            checks++; if ({payload_vld, payload_sof, payload_eof} !== {i >= 8, i == 8, i == 9})
                begin errors++; $display("FAIL valid_payload beat=%0d got=%b exp=%b", i, {payload_vld, payload_sof, payload_eof}, {i >= 8, i == 8, i == 9}); end
            checks++; if (frame_ok !== (i == 9)) begin errors++; $display("FAIL valid_frame_ok beat=%0d got=%b", i, frame_ok); end
        end
        exp_ok++;
        checks++; if (payload_len !== 3'd5) begin errors++; $display("FAIL valid_len got=%0d exp=5", payload_len); end
        checks++; if (msg_count !== 16'd3) begin errors++; $display("FAIL valid_msg_count got=%0d exp=3", msg_count); end
        checks++; if (ok_cnt !== 16'(exp_ok) || drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL valid_counts got=%0d/%0d exp=%0d/%0d", ok_cnt, drop_cnt, exp_ok, exp_drop); end
    endtask

    task automatic test_bad_etype();
        build_frame(16'h1234, 16'd3);
        frm[2][63:48] = 16'h86DD;
        for (int i = 0; i < 10; i++) begin
            send(frm[i], i == 0, i == 9, 3'd0);
            checks++; if (frame_drop !== (i == 2)) begin errors++; $display("FAIL etype_drop beat=%0d got=%b", i, frame_drop); end
            checks++; if (payload_vld !== 1'b0 || frame_ok !== 1'b0) begin errors++; $display("FAIL etype_no_payload beat=%0d vld=%b ok=%b", i, payload_vld, frame_ok); end
            if (i == 2) begin
                exp_drop++;
                checks++; if (drop_cause !== 3'd2) begin errors++; $display("FAIL etype_cause got=%0d exp=2", drop_cause); end
            end
        end
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL etype_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_port_check();
        build_frame(16'h5555, 16'd2);
        for (int i = 0; i < 10; i++) begin
            send(frm[i], i == 0, i == 9, 3'd0);
            if (i == 5) begin
                exp_drop++;
                checks++; if (frame_drop !== 1'b1 || drop_cause !== 3'd5) begin errors++; $display("FAIL port_cause got=%b/%0d exp=1/5", frame_drop, drop_cause); end
            end
        end
        checks++; if (ok_cnt !== 16'(exp_ok) || drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL port_counts got=%0d/%0d exp=%0d/%0d", ok_cnt, drop_cnt, exp_ok, exp_drop); end
        cfg_port_chk_en = 1'b0;
        for (int i = 0; i < 10; i++) send(frm[i], i == 0, i == 9, 3'd2);
        exp_ok++;
        checks++; if (frame_ok !== 1'b1 || payload_eof !== 1'b1) begin errors++; $display("FAIL port_disabled_ok got=%b/%b exp=1/1", frame_ok, payload_eof); end
        checks++; if (ok_cnt !== 16'(exp_ok)) begin errors++; $display("FAIL port_disabled_cnt got=%0d exp=%0d", ok_cnt, exp_ok); end
        cfg_port_chk_en = 1'b1;
    endtask

    task automatic test_heartbeat_eos();
        build_frame(16'h1234, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            send(frm[i], i == 0, i == 9, 3'd4);
            checks++; if ({payload_vld, payload_sof, payload_eof} !== 3'b000) begin errors++; $display("FAIL hb_payload beat=%0d got=%b exp=000", i, {payload_vld, payload_sof, payload_eof}); end
        end
        exp_ok++;
        checks++; if (frame_ok !== 1'b1 || end_of_session !== 1'b0) begin errors++; $display("FAIL hb_ok got=%b/%b exp=1/0", frame_ok, end_of_session); end
        build_frame(16'h1234, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            send(frm[i], i == 0, i == 9, 3'd1);
            checks++; if (end_of_session !== (i == 9)) begin errors++; $display("FAIL eos_pulse beat=%0d got=%b", i, end_of_session); end
        end
        exp_ok++;
        checks++; if (frame_ok !== 1'b1 || payload_vld !== 1'b1) begin errors++; $display("FAIL eos_ok got=%b/%b exp=1/1", frame_ok, payload_vld); end
        checks++; if (msg_count !== 16'hFFFF || ok_cnt !== 16'(exp_ok)) begin errors++; $display("FAIL eos_state got=%h/%0d exp=ffff/%0d", msg_count, ok_cnt, exp_ok); end
    endtask

    task automatic test_runt();
        build_frame(16'h1234, 16'd3);
        for (int i = 0; i < 5; i++) send(frm[i], i == 0, i == 4, 3'd0);
        exp_drop++;
        checks++; if (frame_drop !== 1'b1 || drop_cause !== 3'd6) begin errors++; $display("FAIL runt_w4 got=%b/%0d exp=1/6", frame_drop, drop_cause); end
        send(frm[0], 1'b1, 1'b1, 3'd0);
        exp_drop++;
        checks++; if (frame_drop !== 1'b1 || drop_cause !== 3'd6) begin errors++; $display("FAIL runt_single got=%b/%0d exp=1/6", frame_drop, drop_cause); end
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL runt_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_back_to_back();
        build_frame(16'h1234, 16'd3);
        for (int i = 0; i < 6; i++) send(frm[i], i == 0, 1'b0, 3'd0);
        send(frm[0], 1'b1, 1'b0, 3'd0);
        exp_drop++;
        checks++; if (frame_drop !== 1'b1 || drop_cause !== 3'd7) begin errors++; $display("FAIL abort_cause got=%b/%0d exp=1/7", frame_drop, drop_cause); end
        checks++; if (word_cnt !== 7'd0 || drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL abort_restart got=%0d/%0d exp=0/%0d", word_cnt, drop_cnt, exp_drop); end
        for (int i = 1; i < 10; i++) send(frm[i], 1'b0, i == 9, 3'd3);
        exp_ok++;
        checks++; if (frame_ok !== 1'b1 || word_cnt !== 7'd9 || ok_cnt !== 16'(exp_ok)) begin errors++; $display("FAIL abort_second got=%b/%0d/%0d exp=1/9/%0d", frame_ok, word_cnt, ok_cnt, exp_ok); end
    endtask

    task automatic test_saturation();
        build_frame(16'h1234, 16'd2);
        for (int i = 0; i < 131; i++) begin
            send((i < 10) ? frm[i] : 64'(i), i == 0, i == 130, 3'd6);
            if (i == 127 || i == 130) begin
                checks++; if (word_cnt !== 7'd127) begin errors++; $display("FAIL sat_word_cnt beat=%0d got=%0d exp=127", i, word_cnt); end
            end
        end
        exp_ok++;
        checks++; if (frame_ok !== 1'b1 || payload_eof !== 1'b1 || payload_len !== 3'd6) begin errors++; $display("FAIL sat_end got=%b/%b/%0d exp=1/1/6", frame_ok, payload_eof, payload_len); end
    endtask

    task automatic test_stalls();
        build_frame(16'h1234, 16'd3);
        for (int i = 0; i < 10; i++) begin
            send(frm[i], i == 0, i == 9, 3'd7);
            checks++; if (word_cnt !== 7'(i) || payload_vld !== (i >= 8)) begin errors++; $display("FAIL stall_beat beat=%0d got=%0d/%b", i, word_cnt, payload_vld); end
            if (i != 9 && (i % 3) != 1) begin
                stall();
                checks++; if ({eth_en, ip_en, udp_en, mold_en, payload_vld, payload_sof, frame_ok, frame_drop} !== 8'b0 || word_cnt !== 7'(i))
                    begin errors++; $display("FAIL stall_quiet beat=%0d word=%0d", i, word_cnt); end
            end
        end
        exp_ok++;
        checks++; if (frame_ok !== 1'b1 || payload_len !== 3'd7 || ok_cnt !== 16'(exp_ok)) begin errors++; $display("FAIL stall_end got=%b/%0d/%0d exp=1/7/%0d", frame_ok, payload_len, ok_cnt, exp_ok); end
    endtask

    task automatic test_reset_midframe();
        build_frame(16'h1234, 16'd3);
        for (int i = 0; i < 4; i++) send(frm[i], i == 0, 1'b0, 3'd0);
        checks++; if (word_cnt !== 7'd3 || ip_en !== 1'b1) begin errors++; $display("FAIL pre_reset got=%0d/%b exp=3/1", word_cnt, ip_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (word_cnt !== 7'd0 || data_out !== 64'd0 || ip_en !== 1'b0) begin errors++; $display("FAIL midreset_outputs got=%0d/%h/%b", word_cnt, data_out, ip_en); end
        checks++; if (ok_cnt !== 16'd0 || drop_cnt !== 16'd0 || msg_count !== 16'd0) begin errors++; $display("FAIL midreset_counters got=%0d/%0d/%0d", ok_cnt, drop_cnt, msg_count); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 4; i < 10; i++) send(frm[i], 1'b0, i == 9, 3'd0);
        checks++; if (frame_ok !== 1'b0 || ok_cnt !== 16'd0 || word_cnt !== 7'd0) begin errors++; $display("FAIL midreset_tail got=%b/%0d/%0d exp=0/0/0", frame_ok, ok_cnt, word_cnt); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        test_reset();
        test_valid_frame();
        test_bad_etype();
        test_port_check();
        test_heartbeat_eos();
        test_runt();
        test_back_to_back();
        test_saturation();
        test_stalls();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
